spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- Synthesizable SPI NOR flash device model; the target end of the SPI link driven by the flash controller's SPI master.
- Used in FPGA emulation and simulation benches in place of a physical flash part, so the controller and bootloader run against a real protocol responder.
- Supports Mode 0 (CPOL=0, CPHA=0) with commands 03/02/06/04/05/20, a byte-wide internal array and a backdoor preload port.

Parameters:
- MEM_BYTES, 65536, array size in bytes; must be a power of two and at least 4096.
- ADDR_W, 16, array address width; equals log2(MEM_BYTES).
- PROG_CYCLES, 64, clk cycles WIP stays high after a valid page program.
- PAGE_BYTES, 256, page size used for program wrap.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- spi_cs_n  in  1  chip select, active low, asynchronous to clk.
- spi_sck  in  1  SPI clock, asynchronous to clk.
- spi_mosi  in  1  serial data from master.
- spi_miso  out  1  serial data to master.
- spi_miso_oe  out  1  high while the responder drives spi_miso.
- bd_we  in  1  backdoor byte write.
- bd_addr  in  ADDR_W  backdoor address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  backdoor read data, 1-cycle latency.
- busy  out  1  mirrors status WIP.

Behaviour:
- Input capture:
  - cs_n, sck and mosi each pass through a 2-flop synchronizer.
  - SCK rise and fall are detected on the synchronized value.
  - Requirement on the master: SCK high and low phases each ≥4 clk; CS setup and hold ≥4 clk.
- Sampling: MOSI is sampled MSB-first on SCK rise. MISO changes only on SCK fall.
- Reset values: spi_miso=0, spi_miso_oe=0, busy=0, bd_rdata=0, WEL=0, WIP=0, FSM=IDLE, all counters 0. Array contents are not reset.
- Status byte: {6'b0, WEL, WIP}.
- FSM states: IDLE, CMD, ADDR, RD_DATA, PROG_DATA, STAT, IGNORE.
  - IDLE: synchronized CS fall → CMD, bit_cnt=0.
  - CMD: after 8 bits, decode:
    - 03 → ADDR.
    - 02 → ADDR if WEL=1 and WIP=0, else IGNORE.
    - 20 → ADDR if WEL=1 and WIP=0, else IGNORE.
    - 06 → set WEL at the 8th bit unless WIP=1; then IGNORE.
    - 04 → clear WEL unless WIP=1; then IGNORE.
    - 05 → STAT.
    - 03 with WIP=1 → IGNORE.
    - Any other code → IGNORE.
  - ADDR: shift 24 bits. addr = low ADDR_W bits; upper bits are dropped (aliasing).
    - On the 24th rise: 03 → RD_DATA; 02 → PROG_DATA; 20 → IGNORE with erase_armed=1.
  - RD_DATA:
    - Array read issued on the 24th address rise; shift register loaded on the following SCK fall.
    - Bit 7 is driven on that fall; later bits are driven on each subsequent fall.
    - On each 8th-bit rise: addr+1, wrapping modulo MEM_BYTES, and the next byte is prefetched.
    - Reading continues until CS rises.
  - PROG_DATA: each complete received byte is written as mem[addr] & byte (program clears bits only).
    - Address increments within the page only: addr[7:0] wraps, upper bits are fixed.
    - prog_armed=1 after the first complete byte.
  - STAT: status byte shifts out repeatedly and is re-sampled live each byte, so WIP falling is visible mid-transfer.
  - IGNORE: no action until CS rises.
- spi_miso_oe: 1 from the first drive in RD_DATA or STAT until CS rise; otherwise 0 with spi_miso=0.
- CS rise (any state): FSM → IDLE; miso/oe → 0; bit_cnt cleared. A partial byte is discarded and never written.
  - prog_armed → WIP=1 for PROG_CYCLES clk, then WIP=0 and WEL=0.
  - erase_armed, and bit_cnt was at a byte boundary (exactly 32 bits) → erase engine runs.
    - Writes 0xFF to the 4 KiB sector addr & ~0xFFF, one byte per clk, 4096 clk.
    - WIP=1 throughout; on completion WIP=0 and WEL=0.
  - erase_armed, but CS rose off a byte boundary → erase is cancelled; WEL is unchanged.
- Backdoor and array port arbitration:
  - The array has one write port.
  - Priority: erase engine > SPI program > bd_we.
  - A blocked bd_we write is dropped.
  - Reads for bd_rdata and SPI prefetch use a second read port.
- rst mid-operation: FSM, WIP, WEL and the engines clear immediately.
  - A partially erased sector stays partially erased.
  - The next CS fall after reset release is decoded normally.

Test Plan:
- Backdoor preload 0x0100..0x0103 = 11,22,33,44; SPI 03 00 01 00 plus 32 clocks → MISO bytes 11 22 33 44; oe=1 from the first data bit only.
- 05 with idle status → 0x00. Then 06 and 05 → 0x02. Then 04 and 05 → 0x00.
- 02 00 00 10 with data AA and no WREN → mem[0x10] stays FF, WIP stays 0.
- 06, then 02 00 00 FE with data 0F F0 55 over a preloaded FF page → mem[FE]=0F, mem[FF]=F0, mem[00]=55 (page wrap).
  - RDSR right after CS rise → 03; after PROG_CYCLES → 00.
- 06, then 20 00 12 34 → bytes 0x1000..0x1FFF all FF after 4096 clk, 0x2000 untouched, busy high for exactly 4096 clk.
  - Repeat with CS rising after 30 bits → no erase, WEL still 1.
- Assert rst at 2000 clk into an erase → busy=0 the next cycle; 0x1000..~0x17CF=FF, rest unchanged; a following 03 read returns correct data.

Source files
------------

// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
// spi_flash_responder
//   Synthesizable SPI NOR flash device model (Mode 0), target side of the
//   flash controller's SPI link. Commands: 03 read, 02 page program,
//   06 WREN, 04 WRDI, 05 RDSR, 20 4 KiB sector erase. Byte-wide array with
//   a backdoor port used to preload or inspect contents.
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   spi_cs_n/sck/mosi   SPI inputs, asynchronous to clk (synchronized here)
//   spi_miso/_oe        SPI data out and its drive enable
//   bd_we/addr/wdata    backdoor byte write (lowest write priority)
//   bd_rdata            backdoor read data, one clk after bd_addr
//   busy                status WIP bit
module spi_flash_responder #(
   parameter int MEM_BYTES   = 65536,
   parameter int ADDR_W      = 16,
   parameter int PROG_CYCLES = 64,
   parameter int PAGE_BYTES  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic              bd_we,
   input  logic [ADDR_W-1:0] bd_addr,
   input  logic [7:0]        bd_wdata,
   output logic [7:0]        bd_rdata,
   output logic              busy
);

   localparam int PG_W = $clog2(PAGE_BYTES);
   localparam int PT_W = $clog2(PROG_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_PROG_DATA, S_STAT, S_IGNORE
   } state_t;

   logic [7:0] mem [MEM_BYTES];

   // synchronizers and edge history
   logic cs_s1_q, cs_s2_q, cs_prev_q;
   logic sck_s1_q, sck_s2_q, sck_prev_q;
   logic mosi_s1_q, mosi_s2_q;

   state_t            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;     // bit within current byte
   logic [2:0]        byte_cnt_q, byte_cnt_d;   // completed bytes, saturates at 7
   logic [6:0]        shin_q, shin_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        shout_q, shout_d;
   logic              miso_q, miso_d;
   logic              oe_q, oe_d;
   logic              wel_q, wel_d;
   logic              wip_q, wip_d;
   logic              prog_armed_q, prog_armed_d;
   logic              erase_armed_q, erase_armed_d;
   logic              pt_active_q, pt_active_d;
   logic [PT_W-1:0]   pt_cnt_q, pt_cnt_d;
   logic              er_active_q, er_active_d;
   logic [11:0]       er_cnt_q, er_cnt_d;
   logic [ADDR_W-1:0] er_base_q, er_base_d;
   logic [7:0]        bd_rdata_q;
   logic [7:0]        pf_data_q;                // array data at addr_q, one clk behind

   logic              sck_rise, sck_fall, cs_rise, cs_fall;
   logic [7:0]        rx_byte, tx_src;
   logic              byte_done, addr_last, prog_wr;
   logic              mem_we, mem_and;
   logic [ADDR_W-1:0] mem_waddr;
   logic [7:0]        mem_wdata;

   assign sck_rise  = sck_s2_q & ~sck_prev_q;
   assign sck_fall  = ~sck_s2_q & sck_prev_q;
   assign cs_rise   = cs_s2_q & ~cs_prev_q;
   assign cs_fall   = ~cs_s2_q & cs_prev_q;
   assign rx_byte   = {shin_q, mosi_s2_q};
   assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
   // 24th address bit: command byte plus two address bytes already complete
   assign addr_last = byte_done && (byte_cnt_q == 3'd3);
   assign tx_src    = (state_q == S_STAT) ? {6'b0, wel_q, wip_q} : pf_data_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (cs_rise) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (cs_fall) state_d = S_CMD;
            S_CMD: begin
               if (byte_done) begin
                  case (rx_byte)
                     8'h03:        state_d = wip_q ? S_IGNORE : S_ADDR;
                     8'h02, 8'h20: state_d = (wel_q && !wip_q) ? S_ADDR : S_IGNORE;
                     8'h05:        state_d = S_STAT;
                     default:      state_d = S_IGNORE;
                  endcase
               end
            end
            S_ADDR: begin
               if (addr_last) begin
                  case (cmd_q)
                     8'h03:   state_d = S_RD_DATA;
                     8'h02:   state_d = S_PROG_DATA;
                     default: state_d = S_IGNORE;
                  endcase
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // ---------------- FSM outputs / datapath ----------------
   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      shin_d        = shin_q;
      cmd_d         = cmd_q;
      addr_d        = addr_q;
      shout_d       = shout_q;
      miso_d        = miso_q;
      oe_d          = oe_q;
      wel_d         = wel_q;
      wip_d         = wip_q;
      prog_armed_d  = prog_armed_q;
      erase_armed_d = erase_armed_q;
      pt_active_d   = pt_active_q;
      pt_cnt_d      = pt_cnt_q;
      er_active_d   = er_active_q;
      er_cnt_d      = er_cnt_q;
      er_base_d     = er_base_q;
      prog_wr       = 1'b0;

      // program busy timer
      if (pt_active_q) begin
         if (pt_cnt_q == '0) begin
            pt_active_d = 1'b0;
            wip_d       = 1'b0;
            wel_d       = 1'b0;
         end else begin
            pt_cnt_d = pt_cnt_q - PT_W'(1);
         end
      end
      // erase engine: one 0xFF byte per clk across the sector
      if (er_active_q) begin
         er_cnt_d = er_cnt_q + 12'd1;
         if (er_cnt_q == 12'hFFF) begin
            er_active_d = 1'b0;
            wip_d       = 1'b0;
            wel_d       = 1'b0;
         end
      end

      if (cs_rise) begin
         bit_cnt_d     = '0;
         byte_cnt_d    = '0;
         miso_d        = 1'b0;
         oe_d          = 1'b0;
         prog_armed_d  = 1'b0;
         erase_armed_d = 1'b0;
         if (prog_armed_q) begin
            wip_d       = 1'b1;
            pt_active_d = 1'b1;
            pt_cnt_d    = PT_W'(PROG_CYCLES - 1);
         end
         // erase only when CS rises exactly after the 32nd bit
         if (erase_armed_q && bit_cnt_q == 3'd0 && byte_cnt_q == 3'd4) begin
            wip_d       = 1'b1;
            er_active_d = 1'b1;
            er_cnt_d    = '0;
            er_base_d   = {addr_q[ADDR_W-1:12], 12'h000};
         end
      end else if (state_q == S_IDLE) begin
         if (cs_fall) begin
            bit_cnt_d     = '0;
            byte_cnt_d    = '0;
            prog_armed_d  = 1'b0;
            erase_armed_d = 1'b0;
         end
      end else begin
         if (sck_rise) begin
            shin_d    = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && byte_cnt_q != 3'd7) byte_cnt_d = byte_cnt_q + 3'd1;
         end
         case (state_q)
            S_CMD: begin
               if (byte_done) begin
                  cmd_d = rx_byte;
                  if (rx_byte == 8'h06 && !wip_q) wel_d = 1'b1;
                  if (rx_byte == 8'h04 && !wip_q) wel_d = 1'b0;
               end
            end
            S_ADDR: begin
               // upper address bits fall off the top (aliasing)
               if (sck_rise) addr_d = {addr_q[ADDR_W-2:0], mosi_s2_q};
               if (addr_last && cmd_q == 8'h20) erase_armed_d = 1'b1;
            end
            S_RD_DATA, S_STAT: begin
               if (state_q == S_RD_DATA && byte_done) addr_d = addr_q + ADDR_W'(1);
               // first fall of each byte loads fresh data (prefetch or live status)
               if (sck_fall) begin
                  oe_d = 1'b1;
                  if (bit_cnt_q == 3'd0) {miso_d, shout_d} = {tx_src, 1'b0};
                  else                   {miso_d, shout_d} = {shout_q, 1'b0};
               end
            end
            S_PROG_DATA: begin
               if (byte_done) begin
                  prog_wr      = 1'b1;
                  prog_armed_d = 1'b1;
                  addr_d       = {addr_q[ADDR_W-1:PG_W], addr_q[PG_W-1:0] + PG_W'(1)};
               end
            end
            default: ;
         endcase
      end
   end

   // write port arbitration: erase > SPI program > backdoor
   always_comb begin
      mem_we    = 1'b0;
      mem_and   = 1'b0;
      mem_waddr = bd_addr;
      mem_wdata = bd_wdata;
      if (er_active_q) begin
         mem_we    = 1'b1;
         mem_waddr = er_base_q | ADDR_W'(er_cnt_q);
         mem_wdata = 8'hFF;
      end else if (prog_wr) begin
         mem_we    = 1'b1;
         mem_and   = 1'b1;
         mem_waddr = addr_q;
         mem_wdata = rx_byte;
      end else if (bd_we) begin
         mem_we = 1'b1;
      end
   end

   // array: not reset; writes suppressed during rst so a reset stops erase at once
   always_ff @(posedge clk) begin
      if (mem_we && !rst)
         mem[mem_waddr] <= mem_and ? (mem[mem_waddr] & mem_wdata) : mem_wdata;
      pf_data_q <= mem[addr_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_s1_q       <= 1'b1;
         cs_s2_q       <= 1'b1;
         cs_prev_q     <= 1'b1;
         sck_s1_q      <= 1'b0;
         sck_s2_q      <= 1'b0;
         sck_prev_q    <= 1'b0;
         mosi_s1_q     <= 1'b0;
         mosi_s2_q     <= 1'b0;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         shin_q        <= '0;
         cmd_q         <= '0;
         addr_q        <= '0;
         shout_q       <= '0;
         miso_q        <= 1'b0;
         oe_q          <= 1'b0;
         wel_q         <= 1'b0;
         wip_q         <= 1'b0;
         prog_armed_q  <= 1'b0;
         erase_armed_q <= 1'b0;
         pt_active_q   <= 1'b0;
         pt_cnt_q      <= '0;
         er_active_q   <= 1'b0;
         er_cnt_q      <= '0;
         er_base_q     <= '0;
         bd_rdata_q    <= '0;
      end else begin
         cs_s1_q       <= spi_cs_n;
         cs_s2_q       <= cs_s1_q;
         cs_prev_q     <= cs_s2_q;
         sck_s1_q      <= spi_sck;
         sck_s2_q      <= sck_s1_q;
         sck_prev_q    <= sck_s2_q;
         mosi_s1_q     <= spi_mosi;
         mosi_s2_q     <= mosi_s1_q;
         bit_cnt_q     <= bit_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         shin_q        <= shin_d;
         cmd_q         <= cmd_d;
         addr_q        <= addr_d;
         shout_q       <= shout_d;
         miso_q        <= miso_d;
         oe_q          <= oe_d;
         wel_q         <= wel_d;
         wip_q         <= wip_d;
         prog_armed_q  <= prog_armed_d;
         erase_armed_q <= erase_armed_d;
         pt_active_q   <= pt_active_d;
         pt_cnt_q      <= pt_cnt_d;
         er_active_q   <= er_active_d;
         er_cnt_q      <= er_cnt_d;
         er_base_q     <= er_base_d;
         bd_rdata_q    <= mem[bd_addr];
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign bd_rdata    = bd_rdata_q;
   assign busy        = wip_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
module tb_spi_flash_responder;

   localparam int HP = 6;      // SCK half period in clk
   localparam int PC = 400;    // program time, long enough to observe via RDSR

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_cs_n = 1'b1;
   logic        spi_sck = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe, busy;
   logic        bd_we = 1'b0;
   logic [15:0] bd_addr = '0;
   logic [7:0]  bd_wdata = '0;
   logic [7:0]  bd_rdata;

   int checks = 0;
   int errors = 0;

   spi_flash_responder #(
      .MEM_BYTES(65536), .ADDR_W(16), .PROG_CYCLES(PC), .PAGE_BYTES(256)
   ) dut (
      .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
      .bd_rdata(bd_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #900_000;
      $display("FAIL watchdog: run did not finish, got timeout, expected completion");
      $fatal(1);
   end

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 7 + 3) & 8'h7F;
   endfunction

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_addr = a; bd_wdata = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic bd_read(input logic [15:0] a, output logic [7:0] d);
      bd_addr = a;
      @(negedge clk);
      d = bd_rdata;
   endtask

   task automatic spi_begin();
      spi_cs_n = 1'b0;
      clks(HP);
   endtask

   task automatic spi_end();
      clks(HP);
      spi_cs_n = 1'b1;
      clks(10);
   endtask

   // MSB-first, nb bits; MISO and OE sampled just before each rising SCK
   task automatic spi_xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx,
                           output logic oe_any, output logic oe_all);
      rx = '0; oe_any = 1'b0; oe_all = 1'b1;
      for (int i = 7; i >= 8 - nb; i--) begin
         spi_mosi = tx[i];
         clks(HP);
         rx[i]  = spi_miso;
         oe_any = oe_any | spi_miso_oe;
         oe_all = oe_all & spi_miso_oe;
         spi_sck = 1'b1;
         clks(HP);
         spi_sck = 1'b0;
      end
   endtask

   task automatic spi_cmd1(input logic [7:0] c);
      logic [7:0] rx; logic oa, ol;
      spi_begin();
      spi_xfer(c, 8, rx, oa, ol);
      spi_end();
   endtask

   task automatic rdsr(output logic [7:0] s);
      logic oa, ol; logic [7:0] rx;
      spi_begin();
      spi_xfer(8'h05, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, s, oa, ol);
      spi_end();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clks(4);
      checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", spi_miso_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (bd_rdata !== 8'h00) begin errors++; $display("FAIL reset_bd_rdata got %h exp 00", bd_rdata); end
      rst = 1'b0;
      clks(4);
   endtask

   task automatic test_read();
      logic [7:0] rx, exp; logic oa, ol, cmd_oe, data_oe;
      for (int k = 0; k < 4; k++) bd_write(16'h0100 + 16'(k), 8'(8'h11 * (k + 1)));
      spi_begin();
      cmd_oe = 1'b0;
      spi_xfer(8'h03, 8, rx, oa, ol); cmd_oe |= oa;
      spi_xfer(8'h00, 8, rx, oa, ol); cmd_oe |= oa;
      spi_xfer(8'h01, 8, rx, oa, ol); cmd_oe |= oa;
      spi_xfer(8'h00, 8, rx, oa, ol); cmd_oe |= oa;
      checks++; if (cmd_oe !== 1'b0) begin errors++; $display("FAIL read_oe_cmd got %b exp 0", cmd_oe); end
      data_oe = 1'b1;
      for (int k = 0; k < 4; k++) begin
         spi_xfer(8'h00, 8, rx, oa, ol);
         data_oe &= ol;
         exp = 8'(8'h11 * (k + 1));
         checks++; if (rx !== exp) begin errors++; $display("FAIL read_byte%0d got %h exp %h", k, rx, exp); end
      end
      checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL read_oe_data got %b exp 1", data_oe); end
      spi_end();
      checks++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0)
         begin errors++; $display("FAIL read_release got oe=%b miso=%b exp 0 0", spi_miso_oe, spi_miso); end
   endtask

   task automatic test_status();
      logic [7:0] s;
      rdsr(s);
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL stat_idle got %h exp 00", s); end
      spi_cmd1(8'h06);
      rdsr(s);
      checks++; if (s !== 8'h02) begin errors++; $display("FAIL stat_wren got %h exp 02", s); end
      spi_cmd1(8'h04);
      rdsr(s);
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL stat_wrdi got %h exp 00", s); end
   endtask

   task automatic test_prog_no_wren();
      logic [7:0] rx, d; logic oa, ol;
      bd_write(16'h0010, 8'hFF);
      spi_begin();
      spi_xfer(8'h02, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      spi_xfer(8'h10, 8, rx, oa, ol);
      spi_xfer(8'hAA, 8, rx, oa, ol);
      spi_end();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nowren_busy got %b exp 0", busy); end
      bd_read(16'h0010, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL nowren_mem got %h exp FF", d); end
   endtask

   task automatic test_prog_wrap();
      logic [7:0] rx, d, s; logic oa, ol; int n;
      bd_write(16'h00FE, 8'hFF); bd_write(16'h00FF, 8'hFF);
      bd_write(16'h0000, 8'hFF); bd_write(16'h0001, 8'hFF);
      spi_cmd1(8'h06);
      spi_begin();
      spi_xfer(8'h02, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      spi_xfer(8'hFE, 8, rx, oa, ol);
      spi_xfer(8'h0F, 8, rx, oa, ol);
      spi_xfer(8'hF0, 8, rx, oa, ol);
      spi_xfer(8'h55, 8, rx, oa, ol);
      spi_xfer(8'h00, 4, rx, oa, ol);   // partial byte, must be discarded
      spi_end();
      rdsr(s);
      checks++; if (s !== 8'h03) begin errors++; $display("FAIL prog_stat_busy got %h exp 03", s); end
      n = 0;
      while (busy === 1'b1 && n < 2000) begin clks(1); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prog_busy_timeout got %b exp 0", busy); end
      rdsr(s);
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL prog_stat_done got %h exp 00", s); end
      bd_read(16'h00FE, d);
      checks++; if (d !== 8'h0F) begin errors++; $display("FAIL prog_fe got %h exp 0F", d); end
      bd_read(16'h00FF, d);
      checks++; if (d !== 8'hF0) begin errors++; $display("FAIL prog_ff got %h exp F0", d); end
      bd_read(16'h0000, d);
      checks++; if (d !== 8'h55) begin errors++; $display("FAIL prog_wrap00 got %h exp 55", d); end
      bd_read(16'h0001, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL prog_partial got %h exp FF", d); end
      bd_read(16'h0100, d);
      checks++; if (d !== 8'h11) begin errors++; $display("FAIL prog_nextpage got %h exp 11", d); end
   endtask

   task automatic test_erase();
      logic [7:0] rx, d, s; logic oa, ol, seen; int n, cnt, bad;
      bd_write(16'h0FFF, 8'h3C);
      bd_write(16'h2000, 8'h3C);
      for (int a = 16'h1000; a <= 16'h1FFF; a++) bd_write(16'(a), pat(a));
      spi_cmd1(8'h06);
      spi_begin();
      spi_xfer(8'h20, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      spi_xfer(8'h12, 8, rx, oa, ol);
      spi_xfer(8'h34, 8, rx, oa, ol);
      clks(HP);
      spi_cs_n = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 20) begin clks(1); n++; end
      cnt = 0;
      while (busy === 1'b1 && cnt < 6000) begin clks(1); cnt++; end
      checks++; if (cnt != 4096) begin errors++; $display("FAIL erase_busy_len got %0d exp 4096", cnt); end
      clks(10);
      bad = 0;
      for (int a = 16'h1000; a <= 16'h1FFF; a++) begin bd_read(16'(a), d); if (d !== 8'hFF) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL erase_sector bad_bytes %0d exp 0", bad); end
      bd_read(16'h2000, d);
      checks++; if (d !== 8'h3C) begin errors++; $display("FAIL erase_2000 got %h exp 3C", d); end
      bd_read(16'h0FFF, d);
      checks++; if (d !== 8'h3C) begin errors++; $display("FAIL erase_0fff got %h exp 3C", d); end
      rdsr(s);
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL erase_stat got %h exp 00", s); end

      // CS rising after 30 bits cancels the erase and leaves WEL set
      for (int a = 16'h1000; a <= 16'h100F; a++) bd_write(16'(a), 8'h11);
      spi_cmd1(8'h06);
      spi_begin();
      spi_xfer(8'h20, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      spi_xfer(8'h12, 8, rx, oa, ol);
      spi_xfer(8'h34, 6, rx, oa, ol);
      spi_end();
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin clks(1); seen |= busy; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL erase30_busy got %b exp 0", seen); end
      bad = 0;
      for (int a = 16'h1000; a <= 16'h100F; a++) begin bd_read(16'(a), d); if (d !== 8'h11) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL erase30_mem bad_bytes %0d exp 0", bad); end
      rdsr(s);
      checks++; if (s !== 8'h02) begin errors++; $display("FAIL erase30_stat got %h exp 02", s); end
      spi_cmd1(8'h04);
   endtask

   task automatic test_reset_mid_erase();
      logic [7:0] rx, d, s; logic oa, ol; int n, bad;
      bd_write(16'hFFFF, 8'h9C);
      for (int a = 16'h1000; a <= 16'h1FFF; a++) bd_write(16'(a), pat(a));
      spi_cmd1(8'h06);
      spi_begin();
      spi_xfer(8'h20, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      spi_xfer(8'h10, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      clks(HP);
      spi_cs_n = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 20) begin clks(1); n++; end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rsterase_start got %b exp 1", busy); end
      clks(2000);
      rst = 1'b1;
      clks(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsterase_busy got %b exp 0", busy); end
      rst = 1'b0;
      clks(4);
      bad = 0;
      for (int a = 16'h1000; a <= 16'h17C7; a++) begin bd_read(16'(a), d); if (d !== 8'hFF) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL rsterase_erased bad_bytes %0d exp 0", bad); end
      bad = 0;
      for (int a = 16'h17D8; a <= 16'h1FFF; a++) begin bd_read(16'(a), d); if (d !== pat(a)) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL rsterase_kept bad_bytes %0d exp 0", bad); end
      rdsr(s);
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL rsterase_stat got %h exp 00", s); end
      // aliased address FF_FFFF -> FFFF, then wrap to 0000
      spi_begin();
      spi_xfer(8'h03, 8, rx, oa, ol);
      spi_xfer(8'hFF, 8, rx, oa, ol);
      spi_xfer(8'hFF, 8, rx, oa, ol);
      spi_xfer(8'hFF, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      checks++; if (rx !== 8'h9C) begin errors++; $display("FAIL rd_ffff got %h exp 9C", rx); end
      spi_xfer(8'h00, 8, rx, oa, ol);
      checks++; if (rx !== 8'h55) begin errors++; $display("FAIL rd_wrap0 got %h exp 55", rx); end
      spi_end();
      spi_begin();
      spi_xfer(8'h03, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      spi_xfer(8'h1F, 8, rx, oa, ol);
      spi_xfer(8'hFE, 8, rx, oa, ol);
      spi_xfer(8'h00, 8, rx, oa, ol);
      checks++; if (rx !== pat(16'h1FFE)) begin errors++; $display("FAIL rd_1ffe got %h exp %h", rx, pat(16'h1FFE)); end
      spi_end();
   endtask

   initial begin
      test_reset();
      test_read();
      test_status();
      test_prog_no_wren();
      test_prog_wrap();
      test_erase();
      test_reset_mid_erase();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
